// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encodings and
// the decode helper that picks which operations take the iterative path.
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_NOT = 3'd5;
    localparam logic [OP_W-1:0] OP_MUL = 3'd6;
    localparam logic [OP_W-1:0] OP_DIV = 3'd7;

    // Iteration unit mode select
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    // MUL always iterates; DIV iterates only with a non-zero divisor,
    // the divide-by-zero case is resolved in a single cycle.
    function automatic logic needs_iter(input logic [OP_W-1:0] op,
                                        input logic b_is_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !b_is_zero);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shared iterative engine: shift-add multiplier and restoring divider.
// The accumulator holds {hi, lo}: for MUL {partial product, multiplier},
// for DIV {remainder, quotient}. One iteration is performed per clock,
// the first one on the start edge itself using the live operands, so the
// final value appears on 'wide' (combinational next value) while 'done'
// is high, exactly WIDTH edges after start.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   wide
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               mode_r;
    logic [CNT_W-1:0]   cnt;
    logic               busy;

    logic [2*WIDTH-1:0] cur_acc;
    logic [WIDTH-1:0]   cur_b;
    logic               cur_mode;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] step_acc;

    // One multiply or divide step, fed from the operands on start and
    // from the registered accumulator afterwards.
    always_comb begin
        cur_acc  = acc;
        cur_b    = opb;
        cur_mode = mode_r;
        if (start) begin
            cur_acc  = {{WIDTH{1'b0}}, a};
            cur_b    = b;
            cur_mode = mode;
        end
        mul_sum   = {1'b0, cur_acc[2*WIDTH-1:WIDTH]}
                  + (cur_acc[0] ? {1'b0, cur_b} : {(WIDTH+1){1'b0}});
        div_rem   = {cur_acc[2*WIDTH-1:WIDTH], cur_acc[WIDTH-1]};
        // Remainder stays below the divisor, so bit WIDTH of the trial
        // difference is a reliable sign bit.
        div_trial = div_rem - {1'b0, cur_b};
        if (cur_mode == MODE_MUL) begin
            step_acc = {mul_sum, cur_acc[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            step_acc = {div_trial[WIDTH-1:0], cur_acc[WIDTH-2:0], 1'b1};
        end else begin
            step_acc = {div_rem[WIDTH-1:0], cur_acc[WIDTH-2:0], 1'b0};
        end
    end

    // Accumulator, captured divisor/multiplicand and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            opb    <= '0;
            mode_r <= MODE_MUL;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= step_acc;
            opb    <= b;
            mode_r <= mode;
            cnt    <= CNT_W'(1);
            busy   <= 1'b1;
        end else if (busy) begin
            acc <= step_acc;
            if (done) begin
                cnt  <= '0;
                busy <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign done = busy && (cnt == CNT_W'(WIDTH - 1));
    assign wide = step_acc;

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU between register file and writeback. Single-cycle ops
// (ADD/SUB/logic, DIV by zero) answer one cycle after accept and may be
// issued every cycle; MUL/DIV run on the shared iteration unit for WIDTH
// cycles. All outputs are registered and hold between out_valid pulses.
//
// Handshake: an operation is accepted on a rising edge where in_valid and
// in_ready are both high; A, B and opcode are sampled only at that edge.
// in_ready is high only in IDLE, and in_valid while in_ready is low is
// dropped, never queued. out_valid is a one-cycle pulse with no
// backpressure; the consumer must take the outputs in that cycle.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [OP_W-1:0]      opcode,
    output logic [WIDTH-1:0]     result,
    output logic [2*WIDTH-1:0]   wide_result,
    output logic                 carry,
    output logic                 zero,
    output logic                 div_by_zero,
    output logic                 out_valid,
    output logic [ST_W-1:0]      state_dbg
);

    state_t state, state_nxt;

    logic               accept;
    logic               b_zero;
    logic               iter_start;
    logic               iter_done;
    logic [2*WIDTH-1:0] iter_wide;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   sc_result;
    logic [2*WIDTH-1:0] sc_wide;
    logic               sc_carry;
    logic               sc_dbz;

    assign accept     = in_valid && in_ready;
    assign b_zero     = (B == '0);
    assign iter_start = accept && needs_iter(opcode, b_zero);

    alu_iter_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (iter_start),
        .mode  ((opcode == OP_DIV) ? MODE_DIV : MODE_MUL),
        .a     (A),
        .b     (B),
        .done  (iter_done),
        .wide  (iter_wide)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave IDLE only for iterative ops, return on the last step.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (iter_start) begin
                    state_nxt = (opcode == OP_MUL) ? ST_MUL : ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (iter_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: ready only when idle, state exposed for observation.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        state_dbg = state;
    end

    // Single-cycle results; borrow of SUB is bit WIDTH of the wide difference.
    always_comb begin
        sum       = {1'b0, A} + {1'b0, B};
        diff      = {1'b0, A} - {1'b0, B};
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_dbz    = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_result = sum[WIDTH-1:0];
                sc_carry  = sum[WIDTH];
            end
            OP_SUB: begin
                sc_result = diff[WIDTH-1:0];
                sc_carry  = diff[WIDTH];
            end
            OP_AND:  sc_result = A & B;
            OP_OR:   sc_result = A | B;
            OP_XOR:  sc_result = A ^ B;
            OP_NOT:  sc_result = ~A;
            OP_DIV: begin
                // Only reaches the outputs when B is zero.
                sc_result = '1;
                sc_dbz    = 1'b1;
            end
            default: sc_result = '0;
        endcase
        sc_wide = (opcode == OP_DIV) ? {A, sc_result}
                                     : {{WIDTH{1'b0}}, sc_result};
    end

    // Output registers: loaded on a single-cycle accept or the final
    // iteration, otherwise held; zero reflects the value being registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result      <= '0;
            wide_result <= '0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !iter_start) begin
                result      <= sc_result;
                wide_result <= sc_wide;
                carry       <= sc_carry;
                zero        <= (sc_wide == '0);
                div_by_zero <= sc_dbz;
                out_valid   <= 1'b1;
            end else if ((state != ST_IDLE) && iter_done) begin
                result      <= iter_wide[WIDTH-1:0];
                wide_result <= iter_wide;
                carry       <= 1'b0;
                zero        <= (iter_wide == '0);
                div_by_zero <= 1'b0;
                out_valid   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, clocked successor to the combinational 8-bit ALU. It accepts operands and opcode through a valid/ready handshake. Single-cycle ops (add/sub/logic) complete in one cycle; MUL (shift-add) and DIV (restoring) are iterative. Results, flags and a full-width product/remainder are registered and presented with a one-cycle out_valid pulse. The block sits between the datapath register file and writeback.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands/opcode valid this cycle
in_ready  out  1  block can accept; high only in IDLE
A  in  WIDTH  operand A
B  in  WIDTH  operand B
opcode  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 MUL, 7 DIV
result  out  WIDTH  low result (MUL: product low half; DIV: quotient)
wide_result  out  2*WIDTH  MUL: full product; DIV: {remainder, quotient}; others: zero-extended result
carry  out  1  ADD carry-out; SUB borrow (A<B); 0 otherwise
zero  out  1  1 when wide_result == 0
div_by_zero  out  1  DIV issued with B==0
out_valid  out  1  one-cycle pulse; outputs valid this cycle

Behaviour:
- Reset (async, any time incl. mid-MUL/DIV): state=IDLE, in_ready=1, out_valid=0, result=0, wide_result=0, carry=0, zero=0, div_by_zero=0, counter=0. An in-flight operation is discarded; no out_valid is produced for it.
- Accept: in_valid & in_ready at clock edge. A, B and opcode are captured; later input changes have no effect. in_valid while in_ready=0 is ignored, not queued.
- States: IDLE, MUL, DIV.
  - IDLE: on accepting opcode 0-5, registers results and pulses out_valid the next cycle (latency 1); stays IDLE, so back-to-back accepts every cycle are allowed.
  - IDLE: on accepting MUL, goes to MUL. On accepting DIV with B!=0, goes to DIV.
  - IDLE: on accepting DIV with B==0, finishes in 1 cycle: quotient=all ones, remainder=A, div_by_zero=1.
  - MUL/DIV: run exactly WIDTH iterations, one per clock, with in_ready=0. The last iteration registers outputs, pulses out_valid and returns to IDLE. Latency from accept to out_valid is WIDTH cycles; in_ready is high again in the out_valid cycle.
- Arithmetic: ADD/SUB at WIDTH+1 bits. result=low WIDTH bits, wrapping modulo 2^WIDTH. carry=bit WIDTH for ADD; borrow for SUB.
- MUL: unsigned, exact 2*WIDTH product, no overflow. DIV: unsigned, restoring.
- Flag scope: carry/div_by_zero are 0 for ops where they do not apply. All outputs hold their last values between out_valid pulses. zero is computed from the registered wide_result value.

Decomposition:
- Package alu_pkg holds the opcode localparams (OP_ADD..OP_DIV), state encodings, and the opcode width (3).
- One sub-module, alu_iter_unit: shared shift-add multiplier / restoring divider.
  - Inputs: start, mode, A, B.
  - Outputs: done, wide result.
  - Holds its own iteration counter and accumulator.
- alu_seq owns the handshake, FSM, single-cycle ops and flag registers.

Test Plan:
- WIDTH=8, A=44, B=11, opcodes 0-5 issued back-to-back -> out_valid each cycle, latency 1; results 55, 33, 8, 47, 39, 211; carry=0 for all.
- A=200, B=100, ADD -> result=44, carry=1. SUB with A=11, B=44 -> result=223, carry=1. A=B=5 SUB -> result=0, zero=1.
- A=200, B=100, MUL -> in_ready low for 8 cycles; out_valid 8 cycles after accept; wide_result=0x4E20, result=0x20, zero=0. A pulse of in_valid mid-operation is ignored.
- DIV A=44, B=11 -> quotient 4, remainder 0, wide_result=0x0004. DIV A=200, B=7 -> quotient 28, remainder 4, wide_result=0x041C.
- DIV A=9, B=0 -> 1-cycle latency; result=0xFF, wide_result=0x09FF, div_by_zero=1.
- Assert rst during cycle 4 of a MUL -> all outputs 0 and in_ready=1 immediately, no out_valid. The next ADD A=1, B=2 after reset returns 3.
